mem_word_bridge: RTL

MEM_WORD_BRIDGE -- requirements
Module: mem_word_bridge

---
 rtl/mem_word_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_word_bridge.sv
// ---------------------------------------------------------------------------
// mem_word_bridge
//
// Converts 32-bit word read/write requests into four sequential byte
// accesses on an 8-bit memory. The memory presents read data on the falling
// edge for the address of the current cycle, so each byte is captured on the
// following rising edge. Each access takes 4 byte cycles plus a one-cycle
// DONE state. DONE drives the resp_valid pulse.
//
// Parameters
//   BIG_ENDIAN    : 0 -> byte at base+0 is word bits [7:0]
//                   1 -> byte at base+0 is word bits [31:24]
//   RAM_ADDR_BITS : byte address width; addresses wrap modulo 2^RAM_ADDR_BITS
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (accepted when both high)
//   req_write         : 1 = word write, 0 = word read
//   req_addr          : byte base address (no alignment needed)
//   req_wdata         : write word
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : assembled read word (holds across writes)
//   mem_adr           : byte address to memory
//   mem_memwrite      : byte write strobe
//   mem_writedata     : byte to write
//   mem_memdata       : byte read from memory
// ---------------------------------------------------------------------------
module mem_word_bridge #(
  parameter int BIG_ENDIAN    = 0,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [RAM_ADDR_BITS-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic                     mem_memwrite,
  output logic [7:0]               mem_writedata,
  input  logic [7:0]               mem_memdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [RAM_ADDR_BITS-1:0] adr_q, adr_d;
  logic                     memwrite_q, memwrite_d;
  logic [7:0]               wbyte_q, wbyte_d;
  logic [31:0]              rdata_q, rdata_d;

  // Word lane that holds memory byte k.
  function automatic logic [1:0] lane(input logic [1:0] k);
    return (BIG_ENDIAN != 0) ? (2'd3 - k) : k;
  endfunction

  // Byte k of the latched write word, in memory order.
  logic [7:0] wbytes [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wbytes
      assign wbytes[gi] = wdata_q[{lane(2'(gi)), 3'b000} +: 8];
    end
  endgenerate

  // Reset is folded in so no request can be accepted on a reset edge.
  assign req_ready     = (state_q == IDLE) && !reset;
  assign resp_valid    = (state_q == DONE);
  assign resp_rdata    = rdata_q;
  assign mem_adr       = adr_q;
  assign mem_memwrite  = memwrite_q;
  assign mem_writedata = wbyte_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    adr_d      = adr_q;
    memwrite_d = memwrite_q;
    wbyte_d    = wbyte_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          adr_d   = req_addr;
          cnt_d   = 2'd0;
          wdata_d = req_wdata;
          if (req_write) begin
            state_d    = WRITE;
            memwrite_d = 1'b1;
            // First byte must be on the bus during C1, so take it straight
            // from the request rather than from the latched copy.
            wbyte_d    = (BIG_ENDIAN != 0) ? req_wdata[31:24] : req_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rdata_d[{lane(cnt_q), 3'b000} +: 8] = mem_memdata;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          adr_d = adr_q + RAM_ADDR_BITS'(1);
        end
      end
      WRITE: begin
        if (cnt_q == 2'd3) begin
          state_d    = DONE;
          memwrite_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          adr_d   = adr_q + RAM_ADDR_BITS'(1);
          wbyte_d = wbytes[cnt_q + 2'd1];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      wdata_q    <= 32'd0;
      adr_q      <= '0;
      memwrite_q <= 1'b0;
      wbyte_q    <= 8'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      adr_q      <= adr_d;
      memwrite_q <= memwrite_d;
      wbyte_q    <= wbyte_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule
